// File: rtl/riscv_regfile_wb_arbiter_if.sv
// Write-back bus between the result sources (EX, LSU, APU) and the register-file write ports.
// The slave modport is the arbiter's view; the master modport is the source/register-file side.
interface riscv_regfile_wb_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 2
);
    localparam int unsigned NUM_REGS = 2 ** ADDR_WIDTH;
    localparam int unsigned CNT_W    = $clog2(DEPTH + 1);

    logic                  ex_we_i;
    logic [ADDR_WIDTH-1:0] ex_waddr_i;
    logic [DATA_WIDTH-1:0] ex_wdata_i;

    logic                  lsu_we_i;
    logic [ADDR_WIDTH-1:0] lsu_waddr_i;
    logic [DATA_WIDTH-1:0] lsu_wdata_i;

    logic                  apu_valid_i;
    logic [ADDR_WIDTH-1:0] apu_waddr_i;
    logic [DATA_WIDTH-1:0] apu_wdata_i;
    logic                  apu_ready_o;

    logic                  we_a_o;
    logic [ADDR_WIDTH-1:0] waddr_a_o;
    logic [DATA_WIDTH-1:0] wdata_a_o;

    logic                  we_b_o;
    logic [ADDR_WIDTH-1:0] waddr_b_o;
    logic [DATA_WIDTH-1:0] wdata_b_o;

    logic [NUM_REGS-1:0]   apu_pending_o;
    logic [CNT_W-1:0]      fifo_cnt_o;

    modport slave (
        input  ex_we_i, ex_waddr_i, ex_wdata_i,
        input  lsu_we_i, lsu_waddr_i, lsu_wdata_i,
        input  apu_valid_i, apu_waddr_i, apu_wdata_i,
        output apu_ready_o,
        output we_a_o, waddr_a_o, wdata_a_o,
        output we_b_o, waddr_b_o, wdata_b_o,
        output apu_pending_o, fifo_cnt_o
    );

    modport master (
        output ex_we_i, ex_waddr_i, ex_wdata_i,
        output lsu_we_i, lsu_waddr_i, lsu_wdata_i,
        output apu_valid_i, apu_waddr_i, apu_wdata_i,
        input  apu_ready_o,
        input  we_a_o, waddr_a_o, wdata_a_o,
        input  we_b_o, waddr_b_o, wdata_b_o,
        input  apu_pending_o, fifo_cnt_o
    );
endinterface

// File: rtl/riscv_regfile_wb_arbiter.sv
// Register-file write-back arbiter: EX on W1, LSU > queued APU > (optional) bypassed APU on W2.
// Optional feature macro: RISCV_WB_APU_BYPASS_EN (0-cycle APU path when the FIFO is empty).
module riscv_regfile_wb_arbiter #(
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 2
) (
    input  logic                         clk_int,
    input  logic                         rst_n,
    riscv_regfile_wb_arbiter_if.slave    wb
);
    localparam int unsigned NUM_REGS = 2 ** ADDR_WIDTH;
    localparam int unsigned CNT_W    = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic                  live;
        logic [ADDR_WIDTH-1:0] waddr;
        logic [DATA_WIDTH-1:0] wdata;
    } entry_t;

    entry_t               entry_q [DEPTH];
    entry_t               entry_d [DEPTH];
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    logic                  ex_wr_c;
    logic                  lsu_wr_c;
    logic                  fifo_empty_c;
    logic                  head_live_c;
    logic                  head_dead_c;
    logic                  ready_c;
    logic                  bypass_c;
    logic                  cand_vld_c;
    logic [ADDR_WIDTH-1:0] cand_addr_c;
    logic [DATA_WIDTH-1:0] cand_data_c;
    logic                  head_take_c;
    logic                  pop_c;
    logic                  push_c;
    logic [NUM_REGS-1:0]   pending_c;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign ex_wr_c      = wb.ex_we_i  & (wb.ex_waddr_i  != '0);
    assign lsu_wr_c     = wb.lsu_we_i & (wb.lsu_waddr_i != '0);
    assign fifo_empty_c = (cnt_q == '0);
    assign head_live_c  = ~fifo_empty_c &  entry_q[rd_ptr_q].live;
    assign head_dead_c  = ~fifo_empty_c & ~entry_q[rd_ptr_q].live;
    // Ready looks only at the registered count, so a pop never feeds back into it.
    assign ready_c      = (cnt_q < CNT_W'(DEPTH));

`ifdef RISCV_WB_APU_BYPASS_EN
    assign bypass_c = fifo_empty_c & ~wb.lsu_we_i & wb.apu_valid_i;
`else
    assign bypass_c = 1'b0;
`endif

    // W1 is a straight pass-through of EX; x0 is never written.
    assign wb.we_a_o    = ex_wr_c;
    assign wb.waddr_a_o = wb.ex_waddr_i;
    assign wb.wdata_a_o = wb.ex_wdata_i;

    // W2 candidate selection: LSU, then live FIFO head, then bypassed APU input.
    always_comb begin
        cand_vld_c  = 1'b0;
        cand_addr_c = wb.lsu_waddr_i;
        cand_data_c = wb.lsu_wdata_i;
        head_take_c = 1'b0;
        if (wb.lsu_we_i) begin
            cand_vld_c = 1'b1;
        end else if (head_live_c) begin
            cand_vld_c  = 1'b1;
            cand_addr_c = entry_q[rd_ptr_q].waddr;
            cand_data_c = entry_q[rd_ptr_q].wdata;
            head_take_c = 1'b1;
        end else if (bypass_c) begin
            cand_vld_c  = 1'b1;
            cand_addr_c = wb.apu_waddr_i;
            cand_data_c = wb.apu_wdata_i;
        end
    end

    // EX is the youngest writer, so it wins a same-register collision; x0 is dropped.
    assign wb.we_b_o    = cand_vld_c & (cand_addr_c != '0)
                        & ~(ex_wr_c & (wb.ex_waddr_i == cand_addr_c));
    assign wb.waddr_b_o = cand_addr_c;
    assign wb.wdata_b_o = cand_data_c;

    assign pop_c  = head_take_c | head_dead_c;
    assign push_c = wb.apu_valid_i & ready_c & ~bypass_c;

    // FIFO next state: kill matching entries, retire the head, append the new result.
    always_comb begin
        entry_d  = entry_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if ((ex_wr_c  && (entry_q[i].waddr == wb.ex_waddr_i)) ||
                (lsu_wr_c && (entry_q[i].waddr == wb.lsu_waddr_i))) begin
                entry_d[i].live = 1'b0;
            end
        end
        if (pop_c) begin
            entry_d[rd_ptr_q].live = 1'b0;
            rd_ptr_d               = ptr_inc(rd_ptr_q);
        end
        if (push_c) begin
            entry_d[wr_ptr_q] = '{live: 1'b1, waddr: wb.apu_waddr_i, wdata: wb.apu_wdata_i};
            wr_ptr_d          = ptr_inc(wr_ptr_q);
        end
        case ({push_c, pop_c})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_int or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                entry_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                entry_q[i] <= entry_d[i];
            end
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Popped slots always have live cleared, so only occupied entries can contribute.
    always_comb begin
        pending_c = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (entry_q[i].live) begin
                pending_c = pending_c | (NUM_REGS'(1) << entry_q[i].waddr);
            end
        end
    end

    assign wb.apu_pending_o = pending_c;
    assign wb.fifo_cnt_o    = cnt_q;
    assign wb.apu_ready_o   = ready_c;

endmodule

// File: tb/tb_riscv_regfile_wb_arbiter.sv
// Bench for riscv_regfile_wb_arbiter: directed scenarios plus random traffic against a queue model.
module tb_riscv_regfile_wb_arbiter;
    localparam int unsigned AW    = 6;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 2;
`ifdef RISCV_WB_APU_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic clk_int = 1'b0;
    logic rst_n;
    always #5 clk_int = ~clk_int;

    riscv_regfile_wb_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

    riscv_regfile_wb_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk_int (clk_int),
        .rst_n   (rst_n),
        .wb      (bus.slave)
    );

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        bit            live;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } ent_t;

    ent_t mq[$];
    bit   m_pop, m_push, m_acc;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    // Reference: results queue in arrival order; the oldest live one is offered to W2.
    task automatic model_check();
        bit            exp_we_a, exp_we_b, cand, take_head, byp;
        logic [AW-1:0] ca;
        logic [DW-1:0] cd;
        logic [63:0]   pend;
        int            sz;
        sz        = mq.size();
        exp_we_a  = bus.ex_we_i && (bus.ex_waddr_i != 0);
        cand      = 0;
        take_head = 0;
        byp       = 0;
        ca        = '0;
        cd        = '0;
        if (bus.lsu_we_i) begin
            cand = 1; ca = bus.lsu_waddr_i; cd = bus.lsu_wdata_i;
        end else if (sz > 0 && mq[0].live) begin
            cand = 1; ca = mq[0].addr; cd = mq[0].data; take_head = 1;
        end else if (BYPASS && sz == 0 && bus.apu_valid_i) begin
            cand = 1; ca = bus.apu_waddr_i; cd = bus.apu_wdata_i; byp = 1;
        end
        exp_we_b = cand && (ca != 0) && !(exp_we_a && bus.ex_waddr_i == ca);
        pend = '0;
        foreach (mq[i]) if (mq[i].live) pend[mq[i].addr] = 1'b1;

        check_eq("we_a", 64'(bus.we_a_o), 64'(exp_we_a));
        if (exp_we_a) begin
            check_eq("waddr_a", 64'(bus.waddr_a_o), 64'(bus.ex_waddr_i));
            check_eq("wdata_a", 64'(bus.wdata_a_o), 64'(bus.ex_wdata_i));
        end
        check_eq("we_b", 64'(bus.we_b_o), 64'(exp_we_b));
        if (exp_we_b) begin
            check_eq("waddr_b", 64'(bus.waddr_b_o), 64'(ca));
            check_eq("wdata_b", 64'(bus.wdata_b_o), 64'(cd));
        end
        check_eq("ready", 64'(bus.apu_ready_o), 64'(sz < DEPTH));
        check_eq("pending", 64'(bus.apu_pending_o), pend);
        check_eq("cnt", 64'(bus.fifo_cnt_o), 64'(sz));

        m_pop  = (sz > 0) && (take_head || !mq[0].live);
        m_acc  = bus.apu_valid_i && (sz < DEPTH);
        m_push = m_acc && !byp;
    endtask

    task automatic model_update();
        if (m_pop) void'(mq.pop_front());
        foreach (mq[i]) begin
            if ((bus.ex_we_i && bus.ex_waddr_i != 0 && mq[i].addr == bus.ex_waddr_i) ||
                (bus.lsu_we_i && bus.lsu_waddr_i != 0 && mq[i].addr == bus.lsu_waddr_i))
                mq[i].live = 0;
        end
        if (m_push) mq.push_back('{live: 1'b1, addr: bus.apu_waddr_i, data: bus.apu_wdata_i});
    endtask

    // Inputs are set at posedge+1; model comparison at +3, explicit checks before that at +2.
    task automatic step();
        #1;
        model_check();
        model_update();
        @(posedge clk_int);
        #1;
    endtask

    task automatic drive_ex(input bit we, input int a, input logic [DW-1:0] d);
        bus.ex_we_i = we; bus.ex_waddr_i = AW'(a); bus.ex_wdata_i = d;
    endtask
    task automatic drive_lsu(input bit we, input int a, input logic [DW-1:0] d);
        bus.lsu_we_i = we; bus.lsu_waddr_i = AW'(a); bus.lsu_wdata_i = d;
    endtask
    task automatic drive_apu(input bit v, input int a, input logic [DW-1:0] d);
        bus.apu_valid_i = v; bus.apu_waddr_i = AW'(a); bus.apu_wdata_i = d;
    endtask
    task automatic idle();
        drive_ex(0, 0, '0); drive_lsu(0, 0, '0); drive_apu(0, 0, '0);
    endtask

    initial begin
        logic [63:0] pv;
        idle();
        rst_n = 1'b0;
        #12;
        check_eq("rst_ready", 64'(bus.apu_ready_o), 64'd1);
        check_eq("rst_pending", 64'(bus.apu_pending_o), 64'd0);
        check_eq("rst_cnt", 64'(bus.fifo_cnt_o), 64'd0);
        check_eq("rst_we_b_idle", 64'(bus.we_b_o), 64'd0);
        drive_lsu(1, 4, 32'h1234);
        #1;
        check_eq("rst_we_b_lsu", 64'(bus.we_b_o), 64'd1);
        idle();
        @(posedge clk_int); #1;
        rst_n = 1'b1;

        // EX only, then to x0
        drive_ex(1, 5, 32'hDEADBEEF);
        #1;
        check_eq("ex_we_a", 64'(bus.we_a_o), 64'd1);
        check_eq("ex_waddr_a", 64'(bus.waddr_a_o), 64'd5);
        check_eq("ex_we_b", 64'(bus.we_b_o), 64'd0);
        step();
        drive_ex(1, 0, 32'hDEADBEEF);
        #1;
        check_eq("ex_x0_we_a", 64'(bus.we_a_o), 64'd0);
        step();
        drive_ex(0, 0, '0);

        // LSU holds W2 while the APU fills the FIFO
        drive_lsu(1, 7, 32'hAAAA);
        drive_apu(1, 8, 32'h11); step();
        drive_apu(1, 9, 32'h22); step();
        drive_apu(1, 10, 32'h33);
        #1;
        pv = 64'(bus.apu_pending_o);
        check_eq("full_ready", 64'(bus.apu_ready_o), 64'd0);
        check_eq("full_cnt", 64'(bus.fifo_cnt_o), 64'd2);
        check_eq("pend_8_9", 64'(pv[9:8]), 64'd3);
        step();
        drive_lsu(0, 0, '0);
        #1;
        check_eq("drain_x8", 64'({bus.we_b_o, bus.waddr_b_o}), 64'({1'b1, 6'd8}));
        step();
        #1;
        check_eq("drain_x9", 64'({bus.we_b_o, bus.waddr_b_o}), 64'({1'b1, 6'd9}));
        check_eq("x10_ready", 64'(bus.apu_ready_o), 64'd1);
        step();
        drive_apu(0, 0, '0);
        #1;
        check_eq("drain_x10", 64'(bus.waddr_b_o), 64'd10);
        check_eq("drain_x10_data", 64'(bus.wdata_b_o), 64'h33);
        step();

        // Same-cycle collision with the FIFO head
        drive_lsu(1, 7, 32'hBBBB); drive_apu(1, 3, 32'h2); step();
        drive_lsu(0, 0, '0); drive_apu(0, 0, '0); drive_ex(1, 3, 32'h1);
        #1;
        check_eq("col_we_a", 64'(bus.we_a_o), 64'd1);
        check_eq("col_we_b", 64'(bus.we_b_o), 64'd0);
        check_eq("col_cnt_before", 64'(bus.fifo_cnt_o), 64'd1);
        step();
        drive_ex(0, 0, '0);
        #1;
        check_eq("col_cnt_after", 64'(bus.fifo_cnt_o), 64'd0);
        step();

        // Kill a queued entry
        drive_lsu(1, 7, 32'hCCCC); drive_apu(1, 12, 32'h77); step();
        drive_apu(0, 0, '0); drive_ex(1, 12, 32'h99); step();
        drive_ex(0, 0, '0); drive_lsu(0, 0, '0);
        #1;
        pv = 64'(bus.apu_pending_o);
        check_eq("kill_pend12", 64'(pv[12]), 64'd0);
        check_eq("kill_we_b", 64'(bus.we_b_o), 64'd0);
        check_eq("kill_cnt", 64'(bus.fifo_cnt_o), 64'd1);
        step();
        #1;
        check_eq("kill_popped", 64'(bus.fifo_cnt_o), 64'd0);
        step();

        // APU to empty FIFO: same cycle with bypass, next cycle without
        drive_apu(1, 33, 32'h5);
        #1;
        check_eq("byp_we_b_accept", 64'(bus.we_b_o), 64'(BYPASS));
        step();
        drive_apu(0, 0, '0);
        #1;
        check_eq("byp_we_b_next", 64'(bus.we_b_o), 64'(!BYPASS));
        step();

        // Reset with two entries queued
        drive_lsu(1, 7, 32'hDDDD);
        drive_apu(1, 20, 32'h20); step();
        drive_apu(1, 21, 32'h21); step();
        idle();
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("mrst_cnt", 64'(bus.fifo_cnt_o), 64'd0);
        check_eq("mrst_pending", 64'(bus.apu_pending_o), 64'd0);
        check_eq("mrst_ready", 64'(bus.apu_ready_o), 64'd1);
        mq.delete();
        @(posedge clk_int); #1;
        @(posedge clk_int); #1;
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            check_eq("mrst_no_w2", 64'(bus.we_b_o), 64'd0);
            step();
        end

        // Random traffic on a narrow address range to provoke kills and collisions
        m_acc = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            int lsu_pct;
            lsu_pct = (c < 1000) ? 25 : 60;
            drive_ex($urandom_range(0, 1), ($urandom_range(0, 3) == 0) ? $urandom_range(0, 63)
                                                                      : $urandom_range(0, 7),
                     $urandom);
            drive_lsu($urandom_range(0, 99) < lsu_pct, $urandom_range(0, 7), $urandom);
            if (!(bus.apu_valid_i && !m_acc)) begin
                drive_apu($urandom_range(0, 1),
                          ($urandom_range(0, 3) == 0) ? $urandom_range(32, 63) : $urandom_range(0, 7),
                          $urandom);
            end
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
